ula_k_alu: RTL and testbench



---
 rtl/ula_k_alu_pkg.sv | 21 ++
 rtl/ula_k_alu_if.sv | 31 +++
 rtl/ula_k_div8.sv | 30 +++
 rtl/ula_k_alu.sv | 88 ++++++++
 tb/tb_ula_k_alu.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/ula_k_alu_pkg.sv
// ula_k_alu shared package: opcodes, default width, result bundle.
// Imported by the interface, the divider and the ALU top.
package ula_k_alu_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [7:0] OP_ADD = 8'h00;
    localparam logic [7:0] OP_SUB = 8'h01;
    localparam logic [7:0] OP_AND = 8'h02;
    localparam logic [7:0] OP_OR  = 8'h03;
    localparam logic [7:0] OP_MUL = 8'h04;
    localparam logic [7:0] OP_DIV = 8'h05;

    localparam logic [7:0] DIV0_RESULT = 8'hFF;

    typedef struct packed {
        logic                 overflow;
        logic [DEF_WIDTH-1:0] result;
    } alu_out_t;

endpackage

// File: rtl/ula_k_alu_if.sv
// ula_k_alu operand/result bus.
// master drives operands and opcode, slave is the ALU.
interface ula_k_alu_if
    import ula_k_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic [WIDTH-1:0] operator1;
    logic [WIDTH-1:0] operator2;
    logic [7:0]       operation_alu;
    logic [WIDTH-1:0] result_alu;
    logic             overflow;

    modport master (
        output operator1,
        output operator2,
        output operation_alu,
        input  result_alu,
        input  overflow
    );

    modport slave (
        input  operator1,
        input  operator2,
        input  operation_alu,
        output result_alu,
        output overflow
    );

endinterface

// File: rtl/ula_k_div8.sv
// ula_k_div8: combinational restoring divider, one
// compare/subtract/shift stage per quotient bit.
module ula_k_div8
    import ula_k_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             div_by_zero
);

    logic [WIDTH:0] rem;

    assign div_by_zero = (divisor == '0);

    always_comb begin
        rem      = '0;
        quotient = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            rem = {rem[WIDTH-1:0], dividend[i]};
            if (rem >= {1'b0, divisor}) begin
                rem         = rem - {1'b0, divisor};
                quotient[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ula_k_alu.sv
// ula_k_alu: registered 8-bit ALU (add/sub/and/or/mul/div).
// Result and overflow appear one clock after the operands.
module ula_k_alu
    import ula_k_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic        clk,
    input  logic        rst_n,
    ula_k_alu_if.slave  bus
);

    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic               dz;

    logic [WIDTH-1:0]   nxt_res;
    logic               nxt_ovf;
    logic [WIDTH-1:0]   res_q;
    logic               ovf_q;

    assign a    = bus.operator1;
    assign b    = bus.operator2;
    assign sum  = {1'b0, a} + {1'b0, b};
    // Top bit of the widened difference is the borrow.
    assign diff = {1'b0, a} - {1'b0, b};
    assign prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);

    ula_k_div8 #(
        .WIDTH (WIDTH)
    ) u_div (
        .dividend    (a),
        .divisor     (b),
        .quotient    (quo),
        .div_by_zero (dz)
    );

    always_comb begin
        nxt_res = '0;
        nxt_ovf = 1'b0;
        unique case (bus.operation_alu)
            OP_ADD: begin
                nxt_res = sum[WIDTH-1:0];
                nxt_ovf = sum[WIDTH];
            end
            OP_SUB: begin
                nxt_res = diff[WIDTH-1:0];
                nxt_ovf = diff[WIDTH];
            end
            OP_AND: nxt_res = a & b;
            OP_OR:  nxt_res = a | b;
            OP_MUL: begin
                nxt_res = prod[WIDTH-1:0];
                nxt_ovf = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                if (dz) begin
                    nxt_res = WIDTH'(DIV0_RESULT);
                    nxt_ovf = 1'b1;
                end else begin
                    nxt_res = quo;
                end
            end
            default: begin
                nxt_res = '0;
                nxt_ovf = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            res_q <= nxt_res;
            ovf_q <= nxt_ovf;
        end
    end

    assign bus.result_alu = res_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_ula_k_alu.sv
// tb_ula_k_alu: directed vectors plus a random stream
// checked against a one-cycle-delayed arithmetic model.
module tb_ula_k_alu;
    import ula_k_alu_pkg::*;

    logic clk;
    logic rst_n;
    int   nvec;
    int   nerr;

    ula_k_alu_if #(.WIDTH(8)) bus ();

    ula_k_alu #(.WIDTH(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [8:0] got,
                         input logic [8:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got ovf=%0b res=0x%02h, want ovf=%0b res=0x%02h",
                     tag, got[8], got[7:0], exp[8], exp[7:0]);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] x,
                                         input logic [7:0] y,
                                         input logic [7:0] op);
        int ix;
        int iy;
        int r;
        ix = int'(x);
        iy = int'(y);
        case (op)
            8'h00: begin
                r = ix + iy;
                return {r > 255, 8'(r % 256)};
            end
            8'h01: begin
                r = (ix - iy + 256) % 256;
                return {ix < iy, 8'(r)};
            end
            8'h02: return {1'b0, x & y};
            8'h03: return {1'b0, x | y};
            8'h04: begin
                r = ix * iy;
                return {r > 255, 8'(r % 256)};
            end
            8'h05: begin
                if (iy == 0) return 9'h1FF;
                return {1'b0, 8'(ix / iy)};
            end
            default: return 9'h000;
        endcase
    endfunction

    task automatic drive(input logic [7:0] x,
                         input logic [7:0] y,
                         input logic [7:0] op);
        bus.operator1     = x;
        bus.operator2     = y;
        bus.operation_alu = op;
    endtask

    task automatic vec(input string tag,
                       input logic [7:0] x,
                       input logic [7:0] y,
                       input logic [7:0] op,
                       input logic [7:0] er,
                       input logic       eo);
        drive(x, y, op);
        @(posedge clk);
        #1;
        check(tag, {bus.overflow, bus.result_alu}, {eo, er});
    endtask

    logic [8:0] exp_q;
    logic       have;
    logic [7:0] rx;
    logic [7:0] ry;
    logic [7:0] rop;

    initial begin
        nvec  = 0;
        nerr  = 0;
        rst_n = 1'b0;
        drive(8'd200, 8'd100, OP_ADD);
        @(posedge clk);
        #1;
        check("rst_hold0", {bus.overflow, bus.result_alu}, 9'h000);
        @(posedge clk);
        #1;
        check("rst_hold1", {bus.overflow, bus.result_alu}, 9'h000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release", {bus.overflow, bus.result_alu}, {1'b1, 8'd44});

        vec("add_127",  8'd100, 8'd27,  OP_ADD, 8'd127, 1'b0);
        vec("add_wrap", 8'd255, 8'd1,   OP_ADD, 8'd0,   1'b1);
        vec("sub_brw",  8'd10,  8'd20,  OP_SUB, 8'd246, 1'b1);
        vec("sub_ok",   8'd20,  8'd10,  OP_SUB, 8'd10,  1'b0);
        vec("sub_zero", 8'd0,   8'd0,   OP_SUB, 8'd0,   1'b0);
        vec("and",      8'hF0,  8'h3C,  OP_AND, 8'h30,  1'b0);
        vec("or",       8'hF0,  8'h0F,  OP_OR,  8'hFF,  1'b0);
        vec("mul_255",  8'd15,  8'd17,  OP_MUL, 8'd255, 1'b0);
        vec("mul_256",  8'd16,  8'd16,  OP_MUL, 8'd0,   1'b1);
        vec("mul_600",  8'd200, 8'd3,   OP_MUL, 8'd88,  1'b1);
        vec("div_28",   8'd200, 8'd7,   OP_DIV, 8'd28,  1'b0);
        vec("div_0q",   8'd7,   8'd200, OP_DIV, 8'd0,   1'b0);
        vec("div_by1",  8'd255, 8'd1,   OP_DIV, 8'd255, 1'b0);
        vec("div_by0",  8'd50,  8'd0,   OP_DIV, 8'hFF,  1'b1);
        vec("bad_ff",   8'd50,  8'd0,   8'hFF,  8'h00,  1'b0);
        vec("bad_06",   8'd255, 8'd255, 8'h06,  8'h00,  1'b0);
        vec("bad_85",   8'd200, 8'd0,   8'h85,  8'h00,  1'b0);
        vec("bad_80",   8'd255, 8'd1,   8'h80,  8'h00,  1'b0);
        vec("div_255",  8'd255, 8'd255, OP_DIV, 8'd1,   1'b0);
        vec("add_b2b",  8'd128, 8'd128, OP_ADD, 8'd0,   1'b1);

        // Reset enters at step 300 and leaves at 301.
        have = 1'b0;
        for (int i = 0; i < 604; i++) begin
            @(posedge clk);
            #1;
            if (have)
                check("rand", {bus.overflow, bus.result_alu}, exp_q);
            if (i < 600) begin
                rx  = 8'($urandom_range(0, 255));
                ry  = 8'($urandom_range(0, 255));
                rop = 8'(i % 6);
            end else begin
                rx  = 8'($urandom_range(0, 255));
                ry  = 8'($urandom_range(0, 255));
                rop = 8'($urandom_range(6, 255));
            end
            if (i % 50 == 7) ry = 8'd0;
            rst_n = (i == 300) ? 1'b0 : 1'b1;
            drive(rx, ry, rop);
            exp_q = rst_n ? model(rx, ry, rop) : 9'h000;
            have  = 1'b1;
        end
        @(posedge clk);
        #1;
        check("rand_last", {bus.overflow, bus.result_alu}, exp_q);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
